// File: rtl/life_pkg.sv
// Shared types and tile-order helpers for the 8x8 Life array controller.
package life_pkg;

  localparam int TILE_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    SCAN,
    DUMP
  } state_t;

  // Selector bit 1 picks the column half, bit 0 the row half.
  localparam logic [1:0] TILE_TL = 2'b00;
  localparam logic [1:0] TILE_TR = 2'b10;
  localparam logic [1:0] TILE_BL = 2'b01;
  localparam logic [1:0] TILE_BR = 2'b11;

  function automatic logic [1:0] tile_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return TILE_TL;
      2'd1:    return TILE_TR;
      2'd2:    return TILE_BL;
      default: return TILE_BR;
    endcase
  endfunction

endpackage

// File: rtl/life_array_ctrl_if.sv
// Host-side command and tile-stream bundle for life_array_ctrl.
interface life_array_ctrl_if
  import life_pkg::*;
#(
  parameter int GEN_W = 16
);

  logic                 start;
  logic [GEN_W-1:0]     gens;
  logic                 in_valid;
  logic                 in_ready;
  logic [TILE_BITS-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [TILE_BITS-1:0] out_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, gens, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, gens, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/life_gen_timer.sv
// Generation counter and step-gap timer; the controller only reads tick/expired/idle.
module life_gen_timer #(
  parameter int GEN_W    = 16,
  parameter int STEP_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [GEN_W-1:0] gens,
  output logic             tick,
  output logic             expired,
  output logic             idle
);

  localparam int GAP   = (STEP_GAP < 2) ? 2 : STEP_GAP;
  localparam int GAP_W = $clog2(GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

  logic [GEN_W-1:0] remaining;
  logic [GAP_W-1:0] gap_cnt;

  assign idle    = (gap_cnt == '0);
  assign tick    = en && idle && (remaining != '0);
  assign expired = idle && (remaining == '0);

  // The gap runs down even while stepping is held off, so a scan can follow it.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      gap_cnt   <= '0;
    end else if (load) begin
      remaining <= gens;
      gap_cnt   <= '0;
    end else if (tick) begin
      remaining <= remaining - GEN_W'(1);
      gap_cnt   <= GAP_RELOAD;
    end else if (!idle) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

endmodule

// File: rtl/life_array_ctrl.sv
// Clear / load / step / dump sequencer for one 8x8 Life array (four 4x4 tiles).
// Define LIFE_CTRL_STABLE_DET_EN to stop early once a generation repeats.
module life_array_ctrl
  import life_pkg::*;
#(
  parameter int GEN_W    = 16,
  parameter int STEP_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  life_array_ctrl_if.slave     host,
  output logic                 arr_reset,
  output logic [TILE_BITS-1:0] arr_vali,
  output logic [1:0]           arr_vali_selector,
  output logic [1:0]           arr_valo_selector,
  output logic                 arr_write_enb,
  output logic                 arr_step,
  input  logic [TILE_BITS-1:0] arr_valo,
  input  logic [TILE_BITS-1:0] arr_valo_prev
`ifdef LIFE_CTRL_STABLE_DET_EN
  ,
  output logic                 stable
`endif
);

  state_t               state;
  logic [1:0]           tile_idx;
  logic                 rd_pend;
  logic                 out_valid_q;
  logic [TILE_BITS-1:0] out_data_q;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 tmr_load;
  logic                 tmr_en;
  logic                 tmr_tick;
  logic                 tmr_expired;
  logic                 tmr_idle;

  assign wr_fire  = (state == LOAD) && host.in_valid;
  assign rd_fire  = (state == DUMP) && out_valid_q && host.out_ready;
  assign tmr_load = (state == IDLE) && host.start;

  assign host.in_ready  = (state == LOAD);
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign host.busy      = (state != IDLE);
  assign host.done      = rd_fire && (tile_idx == 2'd3);

  assign arr_write_enb     = wr_fire;
  assign arr_vali          = wr_fire ? host.in_data : '0;
  assign arr_vali_selector = wr_fire ? tile_sel(tile_idx) : 2'b00;

`ifdef LIFE_CTRL_STABLE_DET_EN
  logic scan_due;
  logic scan_arm;
  logic scan_ph;
  logic scan_eq;
  assign tmr_en = (state == RUN) && !scan_due;
`else
  logic unused_sig;
  assign unused_sig = ^{tmr_idle, arr_valo_prev};
  assign tmr_en     = (state == RUN);
`endif

  life_gen_timer #(
    .GEN_W   (GEN_W),
    .STEP_GAP(STEP_GAP)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .en     (tmr_en),
    .gens   (host.gens),
    .tick   (tmr_tick),
    .expired(tmr_expired),
    .idle   (tmr_idle)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tile_idx          <= '0;
      rd_pend           <= 1'b0;
      out_valid_q       <= 1'b0;
      out_data_q        <= '0;
      arr_reset         <= 1'b0;
      arr_step          <= 1'b0;
      arr_valo_selector <= 2'b00;
`ifdef LIFE_CTRL_STABLE_DET_EN
      stable            <= 1'b0;
      scan_due          <= 1'b0;
      scan_arm          <= 1'b0;
      scan_ph           <= 1'b0;
      scan_eq           <= 1'b0;
`endif
    end else begin
      arr_step <= tmr_tick;
      case (state)
        IDLE: if (host.start) begin
          state     <= CLEAR;
          arr_reset <= 1'b1;
`ifdef LIFE_CTRL_STABLE_DET_EN
          stable    <= 1'b0;
          scan_arm  <= 1'b0;
          scan_due  <= 1'b0;
`endif
        end
        CLEAR: begin
          arr_reset <= 1'b0;
          tile_idx  <= '0;
          state     <= LOAD;
        end
        // tile_idx wraps back to 0 after tile 3, ready for the dump.
        LOAD: if (wr_fire) begin
          tile_idx <= tile_idx + 2'd1;
          if (tile_idx == 2'd3) begin
            if (tmr_expired) begin
              state             <= DUMP;
              rd_pend           <= 1'b1;
              arr_valo_selector <= TILE_TL;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (tmr_expired) begin
            state             <= DUMP;
            rd_pend           <= 1'b1;
            arr_valo_selector <= TILE_TL;
          end
`ifdef LIFE_CTRL_STABLE_DET_EN
          // Gen 1 is only compared once the array holds a generation it produced itself.
          else if (scan_due && tmr_idle) begin
            state             <= SCAN;
            scan_due          <= 1'b0;
            scan_ph           <= 1'b0;
            scan_eq           <= 1'b1;
            arr_valo_selector <= TILE_TL;
          end
          if (tmr_tick) begin
            scan_arm <= 1'b1;
            scan_due <= scan_arm;
          end
`endif
        end
`ifdef LIFE_CTRL_STABLE_DET_EN
        SCAN: begin
          if (!scan_ph) begin
            scan_ph <= 1'b1;
          end else begin
            scan_ph  <= 1'b0;
            tile_idx <= tile_idx + 2'd1;
            if (tile_idx == 2'd3) begin
              if (scan_eq && (arr_valo == arr_valo_prev)) begin
                stable            <= 1'b1;
                state             <= DUMP;
                rd_pend           <= 1'b1;
                arr_valo_selector <= TILE_TL;
              end else begin
                state             <= RUN;
                arr_valo_selector <= 2'b00;
              end
            end else begin
              scan_eq           <= scan_eq && (arr_valo == arr_valo_prev);
              arr_valo_selector <= tile_sel(tile_idx + 2'd1);
            end
          end
        end
`endif
        DUMP: begin
          if (rd_pend) begin
            out_data_q  <= arr_valo;
            out_valid_q <= 1'b1;
            rd_pend     <= 1'b0;
          end else if (rd_fire) begin
            out_valid_q <= 1'b0;
            tile_idx    <= tile_idx + 2'd1;
            if (tile_idx == 2'd3) begin
              state             <= IDLE;
              arr_valo_selector <= 2'b00;
            end else begin
              arr_valo_selector <= tile_sel(tile_idx + 2'd1);
              rd_pend           <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_array_ctrl.sv
// Bench for life_array_ctrl: behavioural 8x8 Life array stub, Life model and per-cycle checker.
module tb_life_array_ctrl;
  localparam int STEP_GAP = 2;
  localparam logic [1:0] ORDER [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_array_ctrl_if #(.GEN_W(16)) hif();
  logic        arr_reset, arr_write_enb, arr_step;
  logic [15:0] arr_vali, arr_valo, arr_valo_prev;
  logic [1:0]  arr_vali_selector, arr_valo_selector;
`ifdef LIFE_CTRL_STABLE_DET_EN
  logic stable;
`endif

  life_array_ctrl #(.GEN_W(16), .STEP_GAP(STEP_GAP)) dut (
    .clk(clk), .reset(reset), .host(hif),
    .arr_reset(arr_reset), .arr_vali(arr_vali),
    .arr_vali_selector(arr_vali_selector), .arr_valo_selector(arr_valo_selector),
    .arr_write_enb(arr_write_enb), .arr_step(arr_step),
    .arr_valo(arr_valo), .arr_valo_prev(arr_valo_prev)
`ifdef LIFE_CTRL_STABLE_DET_EN
    , .stable(stable)
`endif
  );

  // Grid bit index is row*8+col; tile word bit is col*4+row.
  function automatic logic [15:0] get_tile(input logic [63:0] g, input logic [1:0] s);
    logic [15:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[c*4+r] = g[(int'(s[0])*4 + r)*8 + int'(s[1])*4 + c];
    return w;
  endfunction

  function automatic logic [63:0] put_tile(input logic [63:0] g, input logic [1:0] s, input logic [15:0] w);
    logic [63:0] o;
    o = g;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[(int'(s[0])*4 + r)*8 + int'(s[1])*4 + c] = w[c*4+r];
    return o;
  endfunction

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] o;
    int n;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
              n += int'(g[(r+dr)*8 + c+dc]);
        o[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
      end
    return o;
  endfunction

  function automatic logic [63:0] tiles_to_grid(input logic [15:0] t0, t1, t2, t3);
    return put_tile(put_tile(put_tile(put_tile(64'h0, ORDER[0], t0), ORDER[1], t1), ORDER[2], t2), ORDER[3], t3);
  endfunction

  // Number of steps the controller should issue for a pattern and generation count.
  function automatic int model_steps(input logic [63:0] g0, input int n);
    logic [63:0] g, nx;
    int s;
    g = g0; s = 0;
    for (int i = 1; i <= n; i++) begin
      nx = life_next(g);
      s++;
`ifdef LIFE_CTRL_STABLE_DET_EN
      if (s >= 2 && i < n && nx == g) return s;
`endif
      g = nx;
    end
    return s;
  endfunction

  // Array stub: combinational read, writes/steps/clears on the clock.
  logic [63:0] grid = '0, grid_prev = '0;
  always @(posedge clk) begin
    if (arr_reset) begin
      grid <= '0; grid_prev <= '0;
    end else if (arr_write_enb) begin
      grid <= put_tile(grid, arr_vali_selector, arr_vali);
    end else if (arr_step) begin
      grid_prev <= grid; grid <= life_next(grid);
    end
  end
  assign arr_valo      = get_tile(grid, arr_valo_selector);
  assign arr_valo_prev = get_tile(grid_prev, arr_valo_selector);

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] load_tiles [4];
  logic [15:0] exp_tiles [4];
  int n_reset, n_writes, n_steps, n_out, n_done, cyc_cnt, last_step;
  bit mon_en = 0, expect_busy = 0, prev_stall = 0;
  logic [15:0] prev_od;

  always @(negedge clk) if (mon_en) begin
    cyc_cnt++;
    check("busy", hif.busy, expect_busy);
    check("done_on_last_accept", hif.done, hif.out_valid && hif.out_ready && n_out == 3);
    check("step_write_excl", arr_step && arr_write_enb, 0);
    if (arr_reset) begin
      check("clear_before_load", n_writes, 0);
      n_reset++;
    end
    if (arr_write_enb) begin
      check("write_ready", hif.in_ready, 1);
      check("write_count", n_writes < 4, 1);
      check("write_sel", arr_vali_selector, ORDER[n_writes & 3]);
      check("write_data", arr_vali, load_tiles[n_writes & 3]);
      n_writes++;
    end
    if (arr_step) begin
      check("step_after_load", n_writes, 4);
      if (last_step >= 0) begin
`ifdef LIFE_CTRL_STABLE_DET_EN
        check("step_gap", (cyc_cnt - last_step) >= STEP_GAP, 1);
`else
        check("step_gap", cyc_cnt - last_step, STEP_GAP);
`endif
      end
      last_step = cyc_cnt;
      n_steps++;
    end
    if (prev_stall) begin
      check("hold_valid", hif.out_valid, 1);
      check("hold_data", hif.out_data, prev_od);
    end
    prev_stall = hif.out_valid && !hif.out_ready;
    prev_od    = hif.out_data;
    if (hif.out_valid && hif.out_ready) begin
      check("out_count", n_out < 4, 1);
      check("out_word", hif.out_data, exp_tiles[n_out & 3]);
      n_out++;
    end
    if (hif.done) begin
      n_done++;
      expect_busy = 0;
    end
  end

  // Entered and left at posedge+1.
  task automatic run_case(input string name, input logic [15:0] t0, t1, t2, t3,
                          input logic [15:0] e0, e1, e2, e3, input int n,
                          input bit bp, input int abort_step);
    logic [63:0] g;
    int k, cyc, stall, steps;
    bit finished, aborted, acc_in;
    load_tiles = '{t0, t1, t2, t3};
    g = tiles_to_grid(t0, t1, t2, t3);
    steps = model_steps(g, n);
    for (int i = 0; i < steps; i++) g = life_next(g);
    for (int i = 0; i < 4; i++) exp_tiles[i] = get_tile(g, ORDER[i]);
    check({name, ":model0"}, exp_tiles[0], e0);
    check({name, ":model1"}, exp_tiles[1], e1);
    check({name, ":model2"}, exp_tiles[2], e2);
    check({name, ":model3"}, exp_tiles[3], e3);
    n_reset = 0; n_writes = 0; n_steps = 0; n_out = 0; n_done = 0; last_step = -1;
    hif.start = 1'b1; hif.gens = 16'(n);
    @(posedge clk); #1;
    hif.start = 1'b0; expect_busy = 1;
    k = 0; cyc = 0; stall = 0; finished = 0; aborted = 0;
    while (!finished && !aborted && cyc < 3000) begin
      hif.in_valid  = (k < 4) && (!bp || (cyc % 2 == 1));
      hif.in_data   = (k < 4) ? load_tiles[k & 3] : 16'h0;
      hif.out_ready = !bp || (stall >= 5);
      hif.start     = bp && (cyc == 3);
      @(negedge clk); #1;
      if (abort_step != 0 && n_steps >= abort_step) begin
        reset = 1'b1; aborted = 1;
      end else begin
        acc_in = hif.in_valid && hif.in_ready;
        if (hif.out_valid) stall = (hif.out_ready) ? 0 : stall + 1;
        @(posedge clk); #1; cyc++;
        if (acc_in) k++;
        if (n_done > 0) finished = 1;
      end
    end
    hif.in_valid = 0; hif.out_ready = 0; hif.start = 0;
    if (aborted) begin
      @(posedge clk); #1;
      reset = 1'b0; expect_busy = 0;
      @(negedge clk); #1;
      check({name, ":abort_idle"}, {hif.busy, hif.in_ready, hif.out_valid, hif.done, arr_reset,
            arr_write_enb, arr_step, arr_vali_selector, arr_valo_selector}, 0);
      check({name, ":abort_vali"}, arr_vali, 0);
      check({name, ":abort_steps"}, n_steps, abort_step);
    end else begin
      check({name, ":finished"}, finished, 1);
      @(negedge clk); #1;
      check({name, ":steps"}, n_steps, steps);
      check({name, ":clears"}, n_reset, 1);
      check({name, ":writes"}, n_writes, 4);
      check({name, ":words"}, n_out, 4);
      check({name, ":dones"}, n_done, 1);
`ifdef LIFE_CTRL_STABLE_DET_EN
      check({name, ":stable"}, stable, steps < n);
`endif
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    hif.start = 0; hif.gens = '0; hif.in_valid = 0; hif.in_data = '0; hif.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {hif.busy, hif.in_ready, hif.out_valid, hif.done, arr_reset,
          arr_write_enb, arr_step, arr_vali_selector, arr_valo_selector}, 0);
    check("reset_data", {hif.out_data, arr_vali}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    check("pin_blinker", get_tile(life_next(tiles_to_grid(16'h0222, 0, 0, 0)), 2'b00), 16'h0070);
    check("pin_single", life_next(tiles_to_grid(16'h0001, 0, 0, 0)), 0);
`ifdef LIFE_CTRL_STABLE_DET_EN
    check("pin_block_steps", model_steps(tiles_to_grid(16'h8000, 16'h0008, 16'h1000, 16'h0001), 100), 2);
`else
    check("pin_block_steps", model_steps(tiles_to_grid(16'h8000, 16'h0008, 16'h1000, 16'h0001), 100), 100);
`endif

    mon_en = 1;
    run_case("single", 16'h0001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_case("block3", 16'h8000, 16'h0008, 16'h1000, 16'h0001,
             16'h8000, 16'h0008, 16'h1000, 16'h0001, 3, 0, 0);
    run_case("gens0", 16'h0025, 0, 0, 0, 16'h0025, 0, 0, 0, 0, 0, 0);
    run_case("backpressure", 16'h0222, 0, 0, 0, 16'h0070, 0, 0, 0, 1, 1, 0);
    run_case("abort", 16'h8000, 16'h0008, 16'h1000, 16'h0001,
             16'h8000, 16'h0008, 16'h1000, 16'h0001, 10, 0, 2);
    run_case("after_abort", 16'h0222, 0, 0, 0, 16'h0222, 0, 0, 0, 2, 0, 0);
    run_case("block100", 16'h8000, 16'h0008, 16'h1000, 16'h0001,
             16'h8000, 16'h0008, 16'h1000, 16'h0001, 100, 0, 0);
    mon_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
